// File: rtl/serial_right_shifter.sv
// -----------------------------------------------------------------------------
// serial_right_shifter
//
// Purpose:
//   Multi-cycle right-shift unit for the datapath ALU (SRL/SRLI, SRA/SRAI).
//   The operand is shifted one bit per clock. A start/ready/done handshake
//   lets the controller stall the datapath while the unit is busy. The
//   result is registered and held until the next operation completes.
//
// Ports:
//   i_clock    in   1        rising-edge clock
//   i_reset    in   1        asynchronous, active-high; clears all state
//   i_start    in   1        request; accepted on a rising edge while o_ready=1
//   i_operand  in   WIDTH    value to shift, sampled at acceptance
//   i_shamt    in   SHAMT_W  shift amount 0..WIDTH-1, sampled at acceptance
//   i_arith    in   1        1 = arithmetic (sign fill), 0 = logical (zero fill)
//   o_ready    out  1        unit can accept i_start this cycle
//   o_busy     out  1        shift in progress
//   o_done     out  1        one-cycle pulse: o_result holds a new value
//   o_result   out  WIDTH    last completed shift result
// -----------------------------------------------------------------------------
module serial_right_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_operand,
    input  logic [SHAMT_W-1:0] i_shamt,
    input  logic               i_arith,
    output logic               o_ready,
    output logic               o_busy,
    output logic               o_done,
    output logic [WIDTH-1:0]   o_result
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_work;
    logic [SHAMT_W-1:0] r_count;
    logic               r_arith;
    logic [WIDTH-1:0]   r_result;

    logic               w_fill;
    logic [WIDTH-1:0]   w_shifted;

    // The sign bit travels with the shift itself: after each step the MSB
    // still equals the sign latched at acceptance, so re-using it as the
    // fill bit gives arithmetic behaviour without a separate sign register.
    assign w_fill    = r_arith & r_work[WIDTH-1];
    assign w_shifted = (r_work >> 1) | (MSB_MASK & {WIDTH{w_fill}});

    // IDLE and DONE both accept a new request, so back-to-back operations
    // cost no bubble cycle.
    assign o_ready  = (r_state != S_SHIFT);
    assign o_busy   = (r_state == S_SHIFT);
    assign o_done   = (r_state == S_DONE);
    assign o_result = r_result;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_work   <= '0;
            r_count  <= '0;
            r_arith  <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_work  <= i_operand;
                        r_count <= i_shamt;
                        r_arith <= i_arith;
                        if (i_shamt == '0) begin
                            // Zero shift completes on the accept edge itself.
                            r_result <= i_operand;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_SHIFT;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    r_work  <= w_shifted;
                    r_count <= r_count - SHAMT_W'(1);
                    // Last step: publish the final value straight from the
                    // shifter so intermediate values never reach o_result.
                    if (r_count == SHAMT_W'(1)) begin
                        r_result <= w_shifted;
                        r_state  <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_right_shifter.sv
// -----------------------------------------------------------------------------
// tb_serial_right_shifter
//
// Purpose:
//   Self-checking bench for serial_right_shifter. Each operation pushes its
//   expected result and accept cycle into a scoreboard queue; the entry is
//   popped and compared when o_done is observed. Outputs are sampled on the
//   falling clock edge.
// -----------------------------------------------------------------------------
module tb_serial_right_shifter;

    localparam int W  = 32;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  operand;
    logic [SW-1:0] shamt;
    logic          arith;
    logic          ready;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [W-1:0] res;
        int           c0;
        int           sh;
    } exp_t;

    exp_t sbq[$];

    serial_right_shifter #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .i_clock   (clk),
        .i_reset   (rst),
        .i_start   (start),
        .i_operand (operand),
        .i_shamt   (shamt),
        .i_arith   (arith),
        .o_ready   (ready),
        .o_busy    (busy),
        .o_done    (done),
        .o_result  (result)
    );

    always #5 clk = ~clk;

    // Rising-edge index; read only on falling edges.
    always @(posedge clk) cyc++;

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] v, input int sh, input logic ar);
        logic signed [W-1:0] s;
        logic [W-1:0]        r;
        s = v;
        if (ar) r = s >>> sh;
        else    r = v >> sh;
        return r;
    endfunction

    // Drive one request for a single cycle and record what it must produce.
    task automatic issue(input logic [W-1:0] op, input int sh, input logic ar, input logic [W-1:0] exp_res);
        exp_t e;
        @(negedge clk);
        operand = op;
        shamt   = sh[SW-1:0];
        arith   = ar;
        start   = 1'b1;
        e.res = exp_res;
        e.c0  = cyc + 1;
        e.sh  = sh;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for o_done; report the cycle it was seen and busy count.
    task automatic wait_done(output int at_cyc, output int busy_n);
        busy_n = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) break;
            if (busy === 1'b1) busy_n++;
            @(negedge clk);
        end
        at_cyc = cyc;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; operand = '0; shamt = '0; arith = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=00000000", result); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (ready !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL idle_after_reset ready=%b done=%b want ready=1 done=0", ready, done); end
        $display("reset: checked");
    endtask

    task automatic test_srl;
        int at, bn; exp_t e;
        issue(32'h8000_0000, 4, 1'b0, 32'h0800_0000);
        wait_done(at, bn);
        e = sbq.pop_front();
        total++; if (result !== e.res) begin bad++; $display("FAIL srl_result got=%h want=%h", result, e.res); end
        total++; if (at - e.c0 !== e.sh) begin bad++; $display("FAIL srl_latency got=%0d want=%0d", at - e.c0, e.sh); end
        total++; if (bn !== 4) begin bad++; $display("FAIL srl_busy_cycles got=%0d want=4", bn); end
        $display("srl 80000000>>4 -> %h", result);
    endtask

    task automatic test_sra;
        int at, bn; exp_t e;
        issue(32'h8000_0000, 4, 1'b1, 32'hF800_0000);
        wait_done(at, bn);
        e = sbq.pop_front();
        total++; if (result !== e.res) begin bad++; $display("FAIL sra_neg_result got=%h want=%h", result, e.res); end
        total++; if (at - e.c0 !== e.sh) begin bad++; $display("FAIL sra_neg_latency got=%0d want=%0d", at - e.c0, e.sh); end
        $display("sra 80000000>>>4 -> %h", result);
        issue(32'h7000_0000, 4, 1'b1, 32'h0700_0000);
        wait_done(at, bn);
        e = sbq.pop_front();
        total++; if (result !== e.res) begin bad++; $display("FAIL sra_pos_result got=%h want=%h", result, e.res); end
        $display("sra 70000000>>>4 -> %h", result);
    endtask

    task automatic test_zero_shift;
        int at, bn; exp_t e;
        issue(32'hDEAD_BEEF, 0, 1'b1, 32'hDEAD_BEEF);
        wait_done(at, bn);
        e = sbq.pop_front();
        total++; if (result !== e.res) begin bad++; $display("FAIL zero_result got=%h want=%h", result, e.res); end
        total++; if (at - e.c0 !== 0) begin bad++; $display("FAIL zero_latency got=%0d want=0", at - e.c0); end
        total++; if (bn !== 0) begin bad++; $display("FAIL zero_busy_cycles got=%0d want=0", bn); end
        $display("zero shift deadbeef -> %h", result);
    endtask

    task automatic test_max_shift;
        int at, bn; exp_t e;
        issue(32'hFFFF_FFF0, 31, 1'b1, 32'hFFFF_FFFF);
        wait_done(at, bn);
        e = sbq.pop_front();
        total++; if (result !== e.res) begin bad++; $display("FAIL max_sra_result got=%h want=%h", result, e.res); end
        total++; if (at - e.c0 !== 31) begin bad++; $display("FAIL max_sra_latency got=%0d want=31", at - e.c0); end
        total++; if (bn !== 31) begin bad++; $display("FAIL max_sra_busy got=%0d want=31", bn); end
        $display("sra fffffff0>>>31 -> %h", result);
        issue(32'hFFFF_FFFF, 31, 1'b0, 32'h0000_0001);
        wait_done(at, bn);
        e = sbq.pop_front();
        total++; if (result !== e.res) begin bad++; $display("FAIL max_srl_result got=%h want=%h", result, e.res); end
        total++; if (at - e.c0 !== 31) begin bad++; $display("FAIL max_srl_latency got=%0d want=31", at - e.c0); end
        $display("srl ffffffff>>31 -> %h", result);
    endtask

    task automatic test_start_while_busy;
        exp_t e; int extra;
        @(negedge clk);
        operand = 32'h1234_5678; shamt = 5'd6; arith = 1'b0; start = 1'b1;
        e.res = ref_shift(32'h1234_5678, 6, 1'b0); e.c0 = cyc + 1; e.sh = 6;
        sbq.push_back(e);
        @(negedge clk);
        // Keep requesting with a different operand while the shift runs.
        operand = 32'hFFFF_FFFF; shamt = 5'd1; arith = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) break;
            @(negedge clk);
        end
        start = 1'b0;
        e = sbq.pop_front();
        total++; if (result !== e.res) begin bad++; $display("FAIL busy_ignore_result got=%h want=%h", result, e.res); end
        total++; if (cyc - e.c0 !== 6) begin bad++; $display("FAIL busy_ignore_latency got=%0d want=6", cyc - e.c0); end
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL busy_ignore_extra_done got=%0d want=0", extra); end
        $display("start during shift ignored, result %h", result);
    endtask

    task automatic test_back_to_back;
        int at, bn; exp_t e;
        issue(32'hF0F0_0000, 3, 1'b1, ref_shift(32'hF0F0_0000, 3, 1'b1));
        wait_done(at, bn);
        e = sbq.pop_front();
        total++; if (result !== e.res) begin bad++; $display("FAIL b2b_first_result got=%h want=%h", result, e.res); end
        total++; if (at - e.c0 !== 3) begin bad++; $display("FAIL b2b_first_latency got=%0d want=3", at - e.c0); end
        // Second request in the DONE cycle.
        operand = 32'h0000_00FF; shamt = 5'd2; arith = 1'b0; start = 1'b1;
        e.res = 32'h0000_003F; e.c0 = cyc + 1; e.sh = 2;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_done_gap got=%b want=0", done); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_second_accepted busy got=%b want=1", busy); end
        wait_done(at, bn);
        e = sbq.pop_front();
        total++; if (result !== e.res) begin bad++; $display("FAIL b2b_second_result got=%h want=%h", result, e.res); end
        total++; if (at - e.c0 !== 2) begin bad++; $display("FAIL b2b_second_latency got=%0d want=2", at - e.c0); end
        $display("back-to-back second result %h", result);
    endtask

    task automatic test_reset_mid_op;
        int at, bn, dn; exp_t e;
        @(negedge clk);
        operand = 32'h0001_2340; shamt = 5'd10; arith = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", done); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL midrst_result got=%h want=00000000", result); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dn = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        total++; if (dn !== 0) begin bad++; $display("FAIL midrst_no_done got=%0d want=0", dn); end
        issue(32'h0000_0100, 8, 1'b0, 32'h0000_0001);
        wait_done(at, bn);
        e = sbq.pop_front();
        total++; if (result !== e.res) begin bad++; $display("FAIL post_rst_result got=%h want=%h", result, e.res); end
        total++; if (at - e.c0 !== 8) begin bad++; $display("FAIL post_rst_latency got=%0d want=8", at - e.c0); end
        $display("reset mid-op, then 00000100>>8 -> %h", result);
    endtask

    task automatic test_random;
        int at, bn, sh; exp_t e; logic [W-1:0] op; logic ar;
        for (int k = 0; k < 8; k++) begin
            op = $urandom;
            sh = $urandom_range(0, 31);
            ar = 1'($urandom_range(0, 1));
            issue(op, sh, ar, ref_shift(op, sh, ar));
            wait_done(at, bn);
            e = sbq.pop_front();
            total++; if (result !== e.res) begin bad++; $display("FAIL rand_result op=%h sh=%0d ar=%b got=%h want=%h", op, sh, ar, result, e.res); end
            total++; if (at - e.c0 !== sh) begin bad++; $display("FAIL rand_latency got=%0d want=%0d", at - e.c0, sh); end
            $display("rand %h sh=%0d ar=%b -> %h", op, sh, ar, result);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        operand = '0;
        shamt = '0;
        arith = 1'b0;
        test_reset;
        test_srl;
        test_sra;
        test_zero_shift;
        test_max_shift;
        test_start_while_busy;
        test_back_to_back;
        test_reset_mid_op;
        test_random;
        total++; if (sbq.size() !== 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d want=0", sbq.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
